// File: rtl/syn_tb_mseq_issuer_if.sv
// Command ROM read port and CSB-style register port of the memory-sequencer issuer.
interface syn_tb_mseq_issuer_if #(
    parameter int unsigned CMD_W = 512,
    parameter int unsigned PC_W  = 10
);
    logic             cmd_rd_en;
    logic [PC_W-1:0]  cmd_rd_addr;
    logic [CMD_W-1:0] cmd_rd_data;
    logic             reg_req_vld;
    logic             reg_req_rdy;
    logic             reg_req_write;
    logic [31:0]      reg_req_addr;
    logic [31:0]      reg_req_wdat;
    logic             reg_rd_vld;
    logic [31:0]      reg_rd_data;

    modport master (
        output cmd_rd_en, cmd_rd_addr,
        input  cmd_rd_data,
        output reg_req_vld, reg_req_write, reg_req_addr, reg_req_wdat,
        input  reg_req_rdy, reg_rd_vld, reg_rd_data
    );

    modport slave (
        input  cmd_rd_en, cmd_rd_addr,
        output cmd_rd_data,
        input  reg_req_vld, reg_req_write, reg_req_addr, reg_req_wdat,
        output reg_req_rdy, reg_rd_vld, reg_rd_data
    );
endinterface

// File: rtl/syn_tb_mseq_issuer.sv
// Memory-sequencer command issuer: fetches commands from a ROM, runs register write/read-check
// and wait commands, and exposes cs/curr_cmd so the emulator side can perform memory load/dump.
module syn_tb_mseq_issuer #(
    parameter int unsigned CMD_W = 512,
    parameter int unsigned PC_W  = 10
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    output logic             busy_o,
    output logic [7:0]       cs_o,
    output logic [CMD_W-1:0] curr_cmd_o,
    output logic             dollar_finish_o,
    output logic [7:0]       err_cnt_o,
    syn_tb_mseq_issuer_if.master bus
);

    // Enumerator values are the published cs encodings.
    typedef enum logic [7:0] {
        StIdle    = 8'h00,
        StFetch   = 8'h01,
        StLatch   = 8'h02,
        StDecode  = 8'h03,
        StRegWr   = 8'h10,
        StRegRd   = 8'h11,
        StRdWait  = 8'h12,
        StWait    = 8'h18,
        StMemLd   = 8'h20,
        StMemDmp  = 8'h28,
        StDone    = 8'hFF
    } state_e;

    localparam logic [7:0] OpRegWr  = 8'h01;
    localparam logic [7:0] OpRegRd  = 8'h02;
    localparam logic [7:0] OpWait   = 8'h03;
    localparam logic [7:0] OpMemLd  = 8'h04;
    localparam logic [7:0] OpMemDmp = 8'h05;
    localparam logic [7:0] OpEnd    = 8'h0F;

    localparam logic [PC_W-1:0] PcMax = '1;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CMD_W-1:0] curr_cmd_q, curr_cmd_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [31:0]      wait_cnt_q, wait_cnt_d;
    logic             err_inc;
    logic             advance;

    logic [7:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;

    assign cmd_op   = curr_cmd_q[7:0];
    assign cmd_addr = curr_cmd_q[39:8];
    assign cmd_data = curr_cmd_q[71:40];
    assign cmd_mask = curr_cmd_q[103:72];

    // State and datapath registers; reset drops any in-flight request immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            curr_cmd_q <= '0;
            err_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            curr_cmd_q <= curr_cmd_d;
            err_cnt_q  <= err_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic, including pc advance and the single error event per state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wait_cnt_d = wait_cnt_q;
        err_inc    = 1'b0;
        advance    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            StFetch:  state_d = StLatch;
            StLatch:  state_d = StDecode;
            StDecode: begin
                case (cmd_op)
                    OpRegWr:  state_d = StRegWr;
                    OpRegRd:  state_d = StRegRd;
                    OpWait: begin
                        state_d    = StWait;
                        // A zero-length wait still occupies one cycle.
                        wait_cnt_d = (cmd_data == 32'd0) ? 32'd1 : cmd_data;
                    end
                    OpMemLd:  state_d = StMemLd;
                    OpMemDmp: state_d = StMemDmp;
                    OpEnd:    state_d = StDone;
                    default: begin
                        err_inc = 1'b1;
                        advance = 1'b1;
                    end
                endcase
            end
            StRegWr: begin
                if (bus.reg_req_rdy) advance = 1'b1;
            end
            StRegRd: begin
                if (bus.reg_req_rdy) state_d = StRdWait;
            end
            StRdWait: begin
                if (bus.reg_rd_vld) begin
                    err_inc = ((bus.reg_rd_data & cmd_mask) != (cmd_data & cmd_mask));
                    advance = 1'b1;
                end
            end
            StWait: begin
                if (wait_cnt_q <= 32'd1) advance = 1'b1;
                else                     wait_cnt_d = wait_cnt_q - 32'd1;
            end
            StMemLd:  advance = 1'b1;
            StMemDmp: advance = 1'b1;
            StDone:   state_d = StDone;
            default:  state_d = StIdle;
        endcase

        // Running off the end of the ROM is an error rather than a wrap to command 0.
        if (advance) begin
            if (pc_q == PcMax) begin
                err_inc = 1'b1;
                state_d = StDone;
            end else begin
                pc_d    = pc_q + 1'b1;
                state_d = StFetch;
            end
        end

        err_cnt_d  = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
        curr_cmd_d = (state_q == StLatch) ? bus.cmd_rd_data : curr_cmd_q;
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        bus.cmd_rd_en     = (state_q == StFetch);
        bus.cmd_rd_addr   = pc_q;
        bus.reg_req_vld   = (state_q == StRegWr) || (state_q == StRegRd);
        bus.reg_req_write = (state_q == StRegWr);
        bus.reg_req_addr  = cmd_addr;
        bus.reg_req_wdat  = cmd_data;
        busy_o            = (state_q != StIdle) && (state_q != StDone);
        dollar_finish_o   = (state_q == StDone);
        cs_o              = state_q;
        curr_cmd_o        = curr_cmd_q;
        err_cnt_o         = err_cnt_q;
    end

endmodule

// File: tb/tb_syn_tb_mseq_issuer.sv
module tb_syn_tb_mseq_issuer;

    localparam int unsigned CMD_W = 512;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    always #5 clk = ~clk;

    // DUT A: full-size ROM
    syn_tb_mseq_issuer_if #(.CMD_W(CMD_W), .PC_W(10)) ifa ();
    logic             busy_a, df_a;
    logic [7:0]       cs_a, err_a;
    logic [CMD_W-1:0] cmd_a;

    syn_tb_mseq_issuer #(.CMD_W(CMD_W), .PC_W(10)) dut_a (
        .clk             (clk),
        .resetn          (resetn),
        .start_i         (start_a),
        .busy_o          (busy_a),
        .cs_o            (cs_a),
        .curr_cmd_o      (cmd_a),
        .dollar_finish_o (df_a),
        .err_cnt_o       (err_a),
        .bus             (ifa.master)
    );

    // DUT B: 4-entry ROM, used for the end-of-ROM case
    syn_tb_mseq_issuer_if #(.CMD_W(CMD_W), .PC_W(2)) ifb ();
    logic             busy_b, df_b;
    logic [7:0]       cs_b, err_b;
    logic [CMD_W-1:0] cmd_b;

    syn_tb_mseq_issuer #(.CMD_W(CMD_W), .PC_W(2)) dut_b (
        .clk             (clk),
        .resetn          (resetn),
        .start_i         (start_b),
        .busy_o          (busy_b),
        .cs_o            (cs_b),
        .curr_cmd_o      (cmd_b),
        .dollar_finish_o (df_b),
        .err_cnt_o       (err_b),
        .bus             (ifb.master)
    );

    logic [CMD_W-1:0] rom_a [1024];
    logic [CMD_W-1:0] rom_b [4];

    always @(posedge clk) if (ifa.cmd_rd_en) ifa.cmd_rd_data <= rom_a[ifa.cmd_rd_addr];
    always @(posedge clk) if (ifb.cmd_rd_en) ifb.cmd_rd_data <= rom_b[ifb.cmd_rd_addr];

    // Register slave for A: ready after 'stall' cycles of valid, read data one cycle after accept
    int          stall = 0;
    int          vld_cnt;
    logic        rd_vld;
    logic [31:0] rd_ret = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_cnt <= 0;
            rd_vld  <= 1'b0;
        end else begin
            vld_cnt <= (ifa.reg_req_vld && !ifa.reg_req_rdy) ? vld_cnt + 1 : 0;
            rd_vld  <= ifa.reg_req_vld && ifa.reg_req_rdy && !ifa.reg_req_write;
        end
    end
    assign ifa.reg_req_rdy = (vld_cnt >= stall);
    assign ifa.reg_rd_vld  = rd_vld;
    assign ifa.reg_rd_data = rd_ret;

    assign ifb.reg_req_rdy = 1'b1;
    assign ifb.reg_rd_vld  = 1'b0;
    assign ifb.reg_rd_data = '0;

    // Scoreboard of expected register requests
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdat;
    } txn_t;
    txn_t exp_q[$];

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
        int          stall;
        logic [31:0] ret;
        int          exp_err;
        int          exp_wait;
        int          exp_cyc;
    } vec_t;
    vec_t vt[10];

    int tests = 0;
    int fails = 0;
    int n_cyc, n_wait, n20, n28, f20, f28;
    bit mem_ok;

    function automatic logic [CMD_W-1:0] mk(input logic [7:0] op, input logic [31:0] addr,
                                            input logic [31:0] data, input logic [31:0] mask);
        logic [CMD_W-1:0] c;
        c = '0;
        c[7:0]    = op;
        c[39:8]   = addr;
        c[71:40]  = data;
        c[103:72] = mask;
        c[CMD_W-1:CMD_W-32] = 32'hA5A5_0000 | {24'd0, op};
        return c;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Start DUT A and run to DONE, checking register requests against the scoreboard.
    task automatic run_prog(input int budget);
        txn_t t, e;
        bit   done;
        n_cyc = 0; n_wait = 0; n20 = 0; n28 = 0; f20 = -1; f28 = -1;
        mem_ok = 1'b1;
        done = 1'b0;
        start_a = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (n == 1) chk("busy_after_start", {63'd0, busy_a}, 64'd1);
            if (ifa.reg_req_vld && ifa.reg_req_rdy) begin
                t = '{ifa.reg_req_write, ifa.reg_req_addr, ifa.reg_req_wdat};
                if (exp_q.size() == 0) begin
                    chk("txn_unexpected", {31'd0, t}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn", {31'd0, t}, {31'd0, e});
                end
            end
            if (cs_a == 8'h18) n_wait++;
            if (cs_a == 8'h20) begin
                n20++;
                if (f20 < 0) f20 = n;
                if (cmd_a !== rom_a[0]) mem_ok = 1'b0;
            end
            if (cs_a == 8'h28) begin
                n28++;
                if (f28 < 0) f28 = n;
                if (cmd_a !== rom_a[1]) mem_ok = 1'b0;
            end
            if (df_a) begin
                n_cyc = n;
                done = 1'b1;
                break;
            end
        end
        chk("run_done_in_budget", {63'd0, done}, 64'd1);
        chk("done_cs", {56'd0, cs_a}, 64'hFF);
        chk("done_busy", {63'd0, busy_a}, 64'd0);
        chk("txn_left", exp_q.size(), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        vt[0] = '{8'h01, 32'h5000, 32'h0000CAFE, 32'h0,        0, 32'h0,      0, 0, 8};
        vt[1] = '{8'h01, 32'h1234, 32'hDEADBEEF, 32'h0,        2, 32'h0,      0, 0, 10};
        vt[2] = '{8'h02, 32'h0010, 32'h00000012, 32'hFF,       3, 32'hAB12,   0, 0, 12};
        vt[3] = '{8'h02, 32'h0010, 32'h00000012, 32'hFF,       3, 32'h13,     1, 0, 12};
        vt[4] = '{8'h02, 32'h0020, 32'h00000001, 32'h0,        0, 32'hFFFF,   0, 0, 9};
        vt[5] = '{8'h03, 32'h0,    32'h0,        32'h0,        0, 32'h0,      0, 1, 8};
        vt[6] = '{8'h03, 32'h0,    32'h5,        32'h0,        0, 32'h0,      0, 5, 12};
        vt[7] = '{8'h7E, 32'h0,    32'h0,        32'h0,        0, 32'h0,      1, 0, 7};
        vt[8] = '{8'h0F, 32'h0,    32'h0,        32'h0,        0, 32'h0,      0, 0, 4};
        vt[9] = '{8'h02, 32'h0030, 32'hABCD0000, 32'hFFFF0000, 1, 32'hABCD1234, 0, 0, 10};
        for (int i = 0; i < 1024; i++) rom_a[i] = mk(8'h0F, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) rom_b[i] = mk(8'h04, 32'h0, 32'(i), 32'h0);

        do_reset();
        @(negedge clk);
        chk("rst_cs", {56'd0, cs_a}, 64'h0);
        chk("rst_busy", {63'd0, busy_a}, 64'd0);
        chk("rst_finish", {63'd0, df_a}, 64'd0);
        chk("rst_err", {56'd0, err_a}, 64'd0);
        chk("rst_curr_cmd_zero", {63'd0, cmd_a == '0}, 64'd1);
        chk("rst_vld", {62'd0, ifa.reg_req_vld, ifa.cmd_rd_en}, 64'd0);

        // Single-command programs from the vector table
        for (int i = 0; i < 10; i++) begin
            do_reset();
            rom_a[0] = mk(vt[i].op, vt[i].addr, vt[i].data, vt[i].mask);
            rom_a[1] = mk(8'h0F, 32'h0, 32'h0, 32'h0);
            stall  = vt[i].stall;
            rd_ret = vt[i].ret;
            if (vt[i].op == 8'h01 || vt[i].op == 8'h02)
                exp_q.push_back('{vt[i].op == 8'h01, vt[i].addr, vt[i].data});
            run_prog(200);
            chk($sformatf("v%0d_err", i), {56'd0, err_a}, 64'(vt[i].exp_err));
            chk($sformatf("v%0d_cycles", i), 64'(n_cyc), 64'(vt[i].exp_cyc));
            chk($sformatf("v%0d_wait_cycles", i), 64'(n_wait), 64'(vt[i].exp_wait));
        end

        // Memory load then dump: one cycle each, four cycles apart, curr_cmd stable
        do_reset();
        stall = 0;
        rom_a[0] = mk(8'h04, 32'h100, 32'h11, 32'h0);
        rom_a[1] = mk(8'h05, 32'h200, 32'h22, 32'h0);
        rom_a[2] = mk(8'h0F, 32'h0, 32'h0, 32'h0);
        run_prog(200);
        chk("mem_ld_cycles", 64'(n20), 64'd1);
        chk("mem_dmp_cycles", 64'(n28), 64'd1);
        chk("mem_ld_cycle_index", 64'(f20), 64'd4);
        chk("mem_dmp_gap", 64'(f28 - f20), 64'd4);
        chk("mem_curr_cmd_stable", {63'd0, mem_ok}, 64'd1);

        // Illegal opcode followed by a register write that must still run
        do_reset();
        rom_a[0] = mk(8'h7E, 32'h0, 32'h0, 32'h0);
        rom_a[1] = mk(8'h01, 32'h77, 32'h1, 32'h0);
        rom_a[2] = mk(8'h0F, 32'h0, 32'h0, 32'h0);
        exp_q.push_back('{1'b1, 32'h77, 32'h1});
        run_prog(200);
        chk("illegal_then_wr_err", {56'd0, err_a}, 64'd1);
        chk("illegal_then_wr_cycles", 64'(n_cyc), 64'd11);

        // Reset asserted during a stalled write
        do_reset();
        rom_a[0] = mk(8'h01, 32'h9000, 32'h55, 32'h0);
        rom_a[1] = mk(8'h0F, 32'h0, 32'h0, 32'h0);
        stall = 50;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_vld_before_reset", {56'd0, cs_a}, 64'h10);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_vld", {63'd0, ifa.reg_req_vld}, 64'd0);
        chk("async_rst_cs", {56'd0, cs_a}, 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        stall = 0;
        exp_q.push_back('{1'b1, 32'h9000, 32'h55});
        run_prog(200);
        chk("rerun_cycles", 64'(n_cyc), 64'd8);

        // Error counter saturation across 300 illegal commands
        do_reset();
        for (int i = 0; i < 300; i++) rom_a[i] = mk(8'h7E, 32'h0, 32'h0, 32'h0);
        rom_a[300] = mk(8'h0F, 32'h0, 32'h0, 32'h0);
        run_prog(2000);
        chk("err_saturate", {56'd0, err_a}, 64'hFF);

        // 4-entry ROM without END: four commands, one error, finish; later start ignored
        do_reset();
        begin
            int  loads;
            bit  fin;
            loads = 0;
            fin = 1'b0;
            start_b = 1'b1;
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                start_b = 1'b0;
                if (cs_b == 8'h20) loads++;
                if (df_b) begin
                    fin = 1'b1;
                    break;
                end
            end
            chk("b_finished", {63'd0, fin}, 64'd1);
            chk("b_commands_run", 64'(loads), 64'd4);
            chk("b_err", {56'd0, err_b}, 64'd1);
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            repeat (4) @(negedge clk);
            chk("b_start_in_done_cs", {56'd0, cs_b}, 64'hFF);
            chk("b_start_in_done_busy", {63'd0, busy_b}, 64'd0);
            chk("b_start_in_done_finish", {63'd0, df_b}, 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
